// File: rtl/adc_smoothing_pkg.sv
// Shared definitions for the ADC smoothing block.
//   SHIFT_DEFAULT : default IIR coefficient exponent (alpha = 2^-SHIFT)
//   NUM_CH        : number of ADC channels per frame
//   DATA_W        : width of one channel word
//   state_t       : sequencing FSM state encoding
package adc_smoothing_pkg;

  localparam int SHIFT_DEFAULT = 3;
  localparam int NUM_CH        = 4;
  localparam int DATA_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FILTER  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/adc_smoothing_pulse_sync.sv
// pulse_sync: brings an asynchronous level into the clk domain through a
// two-flop synchronizer and emits a one-cycle pulse on its rising edge.
//   clk   : system clock
//   srst  : synchronous active-high reset (clears all flops)
//   level : asynchronous input level
//   pulse : one-cycle strobe, high when sync2 is high and sync3 is low
module pulse_sync (
  input  logic clk,
  input  logic srst,
  input  logic level,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic sync3_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      sync1_reg <= level;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  // Flops clear on reset, so a level already high at release yields one edge.
  assign pulse = sync2_reg & ~sync3_reg;

endmodule

// File: rtl/adc_smoothing.sv
// adc_smoothing: first-order IIR smoothing of four ADC channels delivered as
// frames by an SPI receiver. One shared adder/subtractor walks the channels
// one per clock.
//   i_clock          : system clock (rising edge)
//   i_reset          : synchronous active-high reset
//   i_data0..3       : channel words, stable while i_data_received is high
//   i_data_received  : asynchronous frame-complete level
//   o_adc0..3        : smoothed values, held between updates
//   o_valid          : one-cycle strobe, o_adc0..3 updated this cycle
//   o_overrun        : sticky, a frame arrived while one was in flight
module adc_smoothing
  import adc_smoothing_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [DATA_W-1:0] i_data3,
  input  logic              i_data_received,
  output logic [DATA_W-1:0] o_adc0,
  output logic [DATA_W-1:0] o_adc1,
  output logic [DATA_W-1:0] o_adc2,
  output logic [DATA_W-1:0] o_adc3,
  output logic              o_valid,
  output logic              o_overrun
);

  localparam int ACC_W = DATA_W + SHIFT;
  localparam int CH_W  = $clog2(NUM_CH);

  state_t            state_reg;
  state_t            state_next;
  logic              frame_edge;

  logic [DATA_W-1:0] data_in [NUM_CH];
  logic [DATA_W-1:0] x_reg   [NUM_CH];
  logic [ACC_W-1:0]  acc_reg [NUM_CH];
  logic [DATA_W-1:0] adc_reg [NUM_CH];
  logic [CH_W-1:0]   ch_reg;
  logic              primed_reg;
  logic              valid_reg;
  logic              overrun_reg;

  // FSM-decoded controls
  logic              capture_en;
  logic              filter_en;
  logic              last_ch;
  logic              done_st;

  // Shared datapath
  logic [ACC_W-1:0]  acc_cur;
  logic [DATA_W-1:0] x_cur;
  logic [ACC_W:0]    acc_sum;
  logic [ACC_W-1:0]  acc_new;

  assign data_in[0] = i_data0;
  assign data_in[1] = i_data1;
  assign data_in[2] = i_data2;
  assign data_in[3] = i_data3;

  pulse_sync u_pulse_sync (
    .clk   (i_clock),
    .srst  (i_reset),
    .level (i_data_received),
    .pulse (frame_edge)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture_en = 1'b0;
    filter_en  = 1'b0;
    done_st    = 1'b0;
    last_ch    = (ch_reg == CH_W'(NUM_CH - 1));
    case (state_reg)
      ST_IDLE: begin
        if (frame_edge) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture_en = 1'b1;
        state_next = ST_FILTER;
      end
      ST_FILTER: begin
        filter_en = 1'b1;
        if (last_ch) state_next = ST_DONE;
      end
      ST_DONE: begin
        done_st    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ shared datapath
  assign acc_cur = acc_reg[ch_reg];
  assign x_cur   = x_reg[ch_reg];

  // One extra bit of headroom for the intermediate acc + x; the final
  // result is bounded by 0xFFFF << SHIFT and always fits ACC_W.
  always_comb begin
    acc_sum = {1'b0, acc_cur} + (ACC_W + 1)'(x_cur) - (ACC_W + 1)'(acc_cur >> SHIFT);
    if (primed_reg) begin
      acc_new = acc_sum[ACC_W-1:0];
    end else begin
      acc_new = ACC_W'(x_cur) << SHIFT;   // first frame preloads the filter
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ch_reg      <= '0;
      primed_reg  <= 1'b0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        x_reg[i]   <= '0;
        acc_reg[i] <= '0;
        adc_reg[i] <= '0;
      end
    end else begin
      valid_reg <= 1'b0;

      // Any edge outside IDLE (including the DONE cycle) drops that frame.
      if (frame_edge && (state_reg != ST_IDLE)) begin
        overrun_reg <= 1'b1;
      end

      if (capture_en) begin
        for (int i = 0; i < NUM_CH; i++) begin
          x_reg[i] <= data_in[i];
        end
        ch_reg <= '0;
      end

      if (filter_en) begin
        acc_reg[ch_reg] <= acc_new;
        ch_reg          <= ch_reg + 1'b1;
        // Outputs are loaded on the edge that enters DONE so that they and
        // o_valid are presented together during the DONE cycle. The last
        // channel's accumulator is being written on this same edge, so its
        // output is taken straight from the adder.
        if (last_ch) begin
          valid_reg <= 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            if (i == NUM_CH - 1) begin
              adc_reg[i] <= DATA_W'(acc_new >> SHIFT);
            end else begin
              adc_reg[i] <= DATA_W'(acc_reg[i] >> SHIFT);
            end
          end
        end
      end

      if (done_st) begin
        primed_reg <= 1'b1;
      end
    end
  end

  assign o_adc0    = adc_reg[0];
  assign o_adc1    = adc_reg[1];
  assign o_adc2    = adc_reg[2];
  assign o_adc3    = adc_reg[3];
  assign o_valid   = valid_reg;
  assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_adc_smoothing.sv
module tb_adc_smoothing;

  localparam int S = 3;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic [15:0] i_data0 = '0;
  logic [15:0] i_data1 = '0;
  logic [15:0] i_data2 = '0;
  logic [15:0] i_data3 = '0;
  logic        i_data_received = 1'b0;
  logic [15:0] o_adc0, o_adc1, o_adc2, o_adc3;
  logic        o_valid, o_overrun;

  int vectors     = 0;
  int miscompares = 0;
  int valid_cnt   = 0;

  // reference model state
  longint      m_acc [4];
  bit          m_primed;
  logic [15:0] m_out [4];
  logic [15:0] fd    [4];
  logic [15:0] dout  [4];

  adc_smoothing #(.SHIFT(S)) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_data0         (i_data0),
    .i_data1         (i_data1),
    .i_data2         (i_data2),
    .i_data3         (i_data3),
    .i_data_received (i_data_received),
    .o_adc0          (o_adc0),
    .o_adc1          (o_adc1),
    .o_adc2          (o_adc2),
    .o_adc3          (o_adc3),
    .o_valid         (o_valid),
    .o_overrun       (o_overrun)
  );

  always #5 i_clock = ~i_clock;

  assign dout[0] = o_adc0;
  assign dout[1] = o_adc1;
  assign dout[2] = o_adc2;
  assign dout[3] = o_adc3;

  always @(negedge i_clock) if (o_valid === 1'b1) valid_cnt++;

  // alpha = 2^-S exponential smoothing; first frame after reset loads directly
  function automatic void model_frame();
    for (int c = 0; c < 4; c++) begin
      if (!m_primed) m_acc[c] = longint'(fd[c]) * (longint'(1) << S);
      else           m_acc[c] = m_acc[c] + longint'(fd[c]) - m_acc[c] / (longint'(1) << S);
      m_out[c] = 16'(m_acc[c] / (longint'(1) << S));
    end
    m_primed = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_acc[c] = 0;
      m_out[c] = '0;
    end
    m_primed = 1'b0;
  endfunction

  task automatic apply_reset();
    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_data();
    i_data0 = fd[0];
    i_data1 = fd[1];
    i_data2 = fd[2];
    i_data3 = fd[3];
  endtask

  // Raise the flag, count clocks until o_valid (bounded), drop flag, idle.
  task automatic send_frame(output int lat);
    drive_data();
    @(negedge i_clock);
    i_data_received = 1'b1;
    lat = 0;
    do begin
      @(negedge i_clock);
      lat++;
    end while (o_valid !== 1'b1 && lat < 40);
    i_data_received = 1'b0;
    repeat (4) @(negedge i_clock);
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (dout[c] !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_adc%0d: got %h expected 0000", c, dout[c]);
      end
    end
    vectors++;
    if (o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b expected 0", o_valid);
    end
    vectors++;
    if (o_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overrun: got %b expected 0", o_overrun);
    end
    $display("reset: outputs %h %h %h %h valid %b overrun %b", o_adc0, o_adc1, o_adc2, o_adc3, o_valid, o_overrun);
  endtask

  task automatic test_first_frame();
    int lat, v0;
    fd[0] = 16'h1000; fd[1] = 16'h0123; fd[2] = 16'hABCD; fd[3] = 16'hFFFF;
    v0 = valid_cnt;
    send_frame(lat);
    model_frame();
    vectors++;
    if (lat != 8) begin
      miscompares++;
      $display("FAIL first_latency: got %0d clocks expected 8", lat);
    end
    vectors++;
    if (valid_cnt - v0 != 1) begin
      miscompares++;
      $display("FAIL first_valid_count: got %0d expected 1", valid_cnt - v0);
    end
    vectors++;
    if (o_adc0 !== 16'h1000) begin
      miscompares++;
      $display("FAIL first_adc0: got %h expected 1000", o_adc0);
    end
    for (int c = 1; c < 4; c++) begin
      vectors++;
      if (dout[c] !== m_out[c]) begin
        miscompares++;
        $display("FAIL first_adc%0d: got %h expected %h", c, dout[c], m_out[c]);
      end
    end
    $display("first frame: latency %0d adc0 %h", lat, o_adc0);
  endtask

  task automatic test_convergence();
    int lat;
    logic [15:0] prev;
    fd[0] = 16'h1800;
    send_frame(lat);
    model_frame();
    vectors++;
    if (o_adc0 !== 16'h1100 || m_acc[0] != 64'h8800) begin
      miscompares++;
      $display("FAIL second_adc0: got %h expected 1100 (model acc %h)", o_adc0, m_acc[0]);
    end
    prev = o_adc0;
    for (int f = 0; f < 70; f++) begin
      send_frame(lat);
      model_frame();
      vectors++;
      if (o_adc0 !== m_out[0] || o_adc0 < prev) begin
        miscompares++;
        $display("FAIL converge_frame%0d: got %h expected %h (prev %h)", f, o_adc0, m_out[0], prev);
      end
      prev = o_adc0;
    end
    vectors++;
    if (o_adc0 < 16'h17FF || o_adc0 > 16'h1801) begin
      miscompares++;
      $display("FAIL converge_final: got %h expected 1800 +/- 1", o_adc0);
    end
    $display("convergence: adc0 settled at %h", o_adc0);
  endtask

  task automatic test_random();
    int lat;
    for (int f = 0; f < 30; f++) begin
      for (int c = 0; c < 4; c++) fd[c] = 16'($urandom);
      send_frame(lat);
      model_frame();
      repeat ($urandom_range(0, 3)) @(negedge i_clock);
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if (dout[c] !== m_out[c]) begin
          miscompares++;
          $display("FAIL random_f%0d_adc%0d: got %h expected %h", f, c, dout[c], m_out[c]);
        end
      end
      $display("random frame %0d: in %h %h %h %h out %h %h %h %h", f, fd[0], fd[1], fd[2], fd[3], o_adc0, o_adc1, o_adc2, o_adc3);
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [15:0] prev [4];
    apply_reset();
    for (int c = 0; c < 4; c++) fd[c] = 16'h0000;
    send_frame(lat);
    model_frame();
    for (int c = 0; c < 4; c++) begin
      fd[c] = 16'hFFFF;
      prev[c] = dout[c];
    end
    for (int f = 0; f < 100; f++) begin
      send_frame(lat);
      model_frame();
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if (dout[c] !== m_out[c] || dout[c] < prev[c]) begin
          miscompares++;
          $display("FAIL sat_f%0d_adc%0d: got %h expected %h (prev %h)", f, c, dout[c], m_out[c], prev[c]);
        end
        prev[c] = dout[c];
      end
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (dout[c] < 16'hFFF8) begin
        miscompares++;
        $display("FAIL sat_final_adc%0d: got %h expected >= fff8", c, dout[c]);
      end
    end
    $display("saturation: outputs %h %h %h %h", o_adc0, o_adc1, o_adc2, o_adc3);
  endtask

  task automatic test_overrun();
    int v0;
    apply_reset();
    fd[0] = 16'h0A0A; fd[1] = 16'h1B1B; fd[2] = 16'h2C2C; fd[3] = 16'h3D3D;
    drive_data();
    v0 = valid_cnt;
    @(negedge i_clock); i_data_received = 1'b1;
    @(negedge i_clock); i_data_received = 1'b0;
    @(negedge i_clock);
    @(negedge i_clock); i_data_received = 1'b1;   // second rise 3 clocks later
    @(negedge i_clock);                           // first frame captured by now
    i_data0 = 16'hDEAD; i_data1 = 16'hBEEF; i_data2 = 16'hCAFE; i_data3 = 16'hF00D;
    repeat (30) @(negedge i_clock);
    i_data_received = 1'b0;
    repeat (4) @(negedge i_clock);
    model_frame();
    vectors++;
    if (valid_cnt - v0 != 1) begin
      miscompares++;
      $display("FAIL overrun_valid_count: got %0d expected 1", valid_cnt - v0);
    end
    vectors++;
    if (o_overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_flag: got %b expected 1", o_overrun);
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (dout[c] !== m_out[c]) begin
        miscompares++;
        $display("FAIL overrun_adc%0d: got %h expected %h", c, dout[c], m_out[c]);
      end
    end
    $display("overrun: overrun %b adc0 %h valids %0d", o_overrun, o_adc0, valid_cnt - v0);
  endtask

  task automatic test_reset_mid_filter();
    int lat, v0;
    fd[0] = 16'h4444; fd[1] = 16'h5555; fd[2] = 16'h6666; fd[3] = 16'h7777;
    send_frame(lat);
    drive_data();
    v0 = valid_cnt;
    @(negedge i_clock); i_data_received = 1'b1;
    repeat (5) @(negedge i_clock);              // FSM is filtering here
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    i_data_received = 1'b0;
    model_reset();
    repeat (20) @(negedge i_clock);
    vectors++;
    if (valid_cnt - v0 != 0) begin
      miscompares++;
      $display("FAIL midreset_valid_count: got %0d expected 0", valid_cnt - v0);
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (dout[c] !== 16'h0000) begin
        miscompares++;
        $display("FAIL midreset_adc%0d: got %h expected 0000", c, dout[c]);
      end
    end
    fd[0] = 16'h2345; fd[1] = 16'h0001; fd[2] = 16'h8000; fd[3] = 16'h7FFF;
    send_frame(lat);
    model_frame();
    vectors++;
    if (o_adc0 !== 16'h2345) begin
      miscompares++;
      $display("FAIL midreset_preload_adc0: got %h expected 2345", o_adc0);
    end
    for (int c = 1; c < 4; c++) begin
      vectors++;
      if (dout[c] !== m_out[c]) begin
        miscompares++;
        $display("FAIL midreset_preload_adc%0d: got %h expected %h", c, dout[c], m_out[c]);
      end
    end
    $display("reset mid-filter: preload adc0 %h", o_adc0);
  endtask

  task automatic test_held_high();
    int v0, lat;
    for (int c = 0; c < 4; c++) fd[c] = 16'($urandom);
    drive_data();
    i_data_received = 1'b1;                      // high across reset release
    apply_reset();
    v0 = valid_cnt;
    repeat (1000) @(negedge i_clock);
    model_frame();
    vectors++;
    if (valid_cnt - v0 != 1) begin
      miscompares++;
      $display("FAIL held_valid_count: got %0d expected 1", valid_cnt - v0);
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (dout[c] !== m_out[c]) begin
        miscompares++;
        $display("FAIL held_adc%0d: got %h expected %h", c, dout[c], m_out[c]);
      end
    end
    i_data_received = 1'b0;
    repeat (5) @(negedge i_clock);
    for (int c = 0; c < 4; c++) fd[c] = 16'($urandom);
    send_frame(lat);
    model_frame();
    vectors++;
    if (valid_cnt - v0 != 2 || lat != 8) begin
      miscompares++;
      $display("FAIL held_second_frame: got %0d valids latency %0d expected 2 valids latency 8", valid_cnt - v0, lat);
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (dout[c] !== m_out[c]) begin
        miscompares++;
        $display("FAIL held_second_adc%0d: got %h expected %h", c, dout[c], m_out[c]);
      end
    end
    $display("held high: valids %0d adc0 %h", valid_cnt - v0, o_adc0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_frame();
    test_convergence();
    test_random();
    test_saturation();
    test_overrun();
    test_reset_mid_filter();
    test_held_high();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_smoothing.md
ADC_SMOOTHING -- requirements
Module: adc_smoothing

Interface
REQ-001 Parameter SHIFT, default 3, IIR smoothing coefficient (alpha = 2^-SHIFT), legal range 0..6.
REQ-002 i_clock  input  1  single system clock; all logic on its rising edge.
REQ-003 i_reset  input  1  reset; synchronous, active-high.
REQ-004 i_data0..i_data3  input  16 each  unsigned channel words from SPI receiver, asynchronous to i_clock, stable while i_data_received high.
REQ-005 i_data_received  input  1  frame-complete flag from SPI receiver, asynchronous level, rises once per 4-word frame.
REQ-006 o_adc0..o_adc3  output  16 each  smoothed channel values, held between updates.
REQ-007 o_valid  output  1  one-cycle strobe: o_adc0..3 updated this cycle.
REQ-008 o_overrun  output  1  sticky: a frame arrived while previous frame still being filtered.

Function
REQ-009 i_data_received SHALL pass a 2-flop synchronizer then rising-edge detect; edge = sync2 high and sync3 low.
REQ-010 FSM states: IDLE, CAPTURE, FILTER, DONE; reset state IDLE.
REQ-011 IDLE: on edge, go CAPTURE; otherwise stay.
REQ-012 CAPTURE (1 cycle): register i_data0..3 into capture regs x[0..3]; channel index ch <= 0; go FILTER.
REQ-013 FILTER: one channel per cycle, ch 0->3; after ch 3 go DONE.
REQ-014 Per channel accumulator acc[ch], width 16+SHIFT, unsigned; update acc <= acc + x - (acc >> SHIFT); invariant 0 <= acc <= 0xFFFF<<SHIFT, no overflow or saturation logic needed.
REQ-015 First frame after reset (primed flag low): acc[ch] <= x << SHIFT instead of REQ-014; primed set in DONE.
REQ-016 o_adcN = acc[N] >> SHIFT (truncation), registered, updated in DONE only.
REQ-017 DONE (1 cycle): load o_adc0..3, o_valid high, go IDLE.
REQ-018 Latency: edge detected at cycle E -> CAPTURE at E+1, FILTER E+2..E+5, o_valid at E+6; total 8 clocks from first i_clock edge sampling i_data_received high.
REQ-019 Edge detected while not IDLE: frame dropped, o_overrun set (sticky until reset), current frame completes unaffected.
REQ-020 Edge coincident with DONE: counts as overrun; FSM still returns to IDLE.
REQ-021 i_data_received held high indefinitely: exactly one frame processed.
REQ-022 SHIFT=0: output equals latest capture each frame.

Reset
REQ-023 On i_reset: FSM IDLE, sync flops 0, acc all 0, primed 0, o_adc0..3 = 0x0000, o_valid 0, o_overrun 0.
REQ-024 Reset mid-FILTER: frame discarded, no o_valid, next frame treated as first (preload).
REQ-025 i_data_received high during reset release: sync flops start 0, so one edge is detected after release.

Structure
REQ-026 Shared package holds: SHIFT default, channel count (4), data width (16), FSM state encoding.
REQ-027 One sub-module pulse_sync: 2-flop synchronizer plus rising-edge detect, synchronous reset.
REQ-028 Single shared adder/subtractor time-multiplexed across channels; no per-channel arithmetic duplication.

Verification
REQ-029 Reset, first frame data0=0x1000 -> o_valid once, o_adc0=0x1000, 8 clocks after flag sampled high.
REQ-030 Second frame data0=0x1800 (SHIFT=3) -> acc0=0x8800, o_adc0=0x1100; repeated 0x1800 converges to within 1 LSB of 0x1800 monotonically.
REQ-031 Sustained 0xFFFF on all channels for 100 frames -> outputs rise to 0xFFFF-0x0007 or higher, never wrap.
REQ-032 Second flag edge 3 clocks after first -> o_overrun=1, exactly one o_valid, outputs from first frame.
REQ-033 i_reset pulsed during FILTER -> no o_valid, outputs 0x0000; next frame 0x2345 -> o_adc0=0x2345 (preload).
REQ-034 Flag held high 1000 clocks -> exactly one o_valid; flag glitch-free low then high -> second o_valid.
